mux4_rr_arbiter: RTL
====================

# mux4_rr_arbiter

Round-robin arbiter and registered output stage that drives the 2-bit select of the 4-way mux datapath. It accepts up to four requesters (A..D), picks one fairly, holds the grant while that requester keeps asking (bounded by a hold limit), and emits the selected input as a registered output with a valid flag. It sits directly upstream of the `mux4` select input and replaces hand-driven `control` bits.

## Interface
- `W`, default 1: data width of each input and of `out`.
- `MAX_HOLD`, default 8: maximum consecutive granted cycles while another request is pending; legal range 1..255.

Ports:
- `clock`, input, 1: sole clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 4: request per source; bit 0 = A, bit 1 = B, bit 2 = C, bit 3 = D.
- `A`, `B`, `C`, `D`, inputs, W each: source data.
- `grant`, output, 4: one-hot current grant; all zero when idle.
- `control`, output, 2: mux select. A = 00, B = 01, C = 10, D = 11.
- `out`, output, W: registered selected data.
- `out_valid`, output, 1: `out` holds data from a granted cycle.

## Operation
- States:
  - IDLE: `grant` = 0.
  - BUSY: exactly one `grant` bit set.
- Pointer `ptr` (2 bits) holds the highest-priority index. Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3` mod 4. The reset value is 0, so A has priority first.
- IDLE, any `req` high: next edge → BUSY. Grant the first requester in search order and set `control` to its index. Clear the hold counter.
- IDLE, no `req`: stay in IDLE. `control` keeps its last value.
- BUSY, granted `req` still high:
  - If no other `req` is high, or the hold counter < `MAX_HOLD`−1: keep the grant and increment the hold counter. The counter saturates at 255.
  - If another `req` is high and the hold counter = `MAX_HOLD`−1: force rotation (see below).
- BUSY, granted `req` low (release): rotate at the next edge.
- Rotation, with g = current granted index:
  - Set `ptr` = g+1.
  - Search from g+1 with g masked out. If a requester is found, grant it directly (no idle bubble) and clear the hold counter.
  - If none is found, go to IDLE with `grant` = 0.
- Hold counter: 8 bits. It counts only while BUSY and is cleared on every new grant.
- Data stage: every edge, `out` ← the input selected by the current `control`, and `out_valid` ← (state was BUSY). When `out_valid` = 0, `out` holds its previous value.
- Reset (asynchronous, at any time including mid-grant):
  - State = IDLE, `ptr` = 0, hold counter = 0.
  - `grant` = 0000, `control` = 00, `out` = 0, `out_valid` = 0.
  - These values apply immediately on `reset_n` low and are held until the first edge after release.

## Timing
- Request to grant: 1 cycle. `req` sampled high at edge n gives `grant`/`control` valid after edge n.
- Grant to data: 1 cycle. After edge n+1, `out` reflects the data sampled at edge n+1 under the cycle-n select, and `out_valid` = 1.
- Release to handoff: 1 cycle. `req[g]` sampled low at edge m gives the new grant (or IDLE) after edge m.
- `out_valid` deasserts 1 cycle after the state returns to IDLE.
- Simultaneous release and hold-limit expiry: treated as a single rotation.
- A `req` change within a cycle has no effect until the next edge.

## Test plan
- Reset: drive `reset_n` low mid-grant with `req` = 0100.
  - → `grant` = 0000, `control` = 00, `out_valid` = 0 immediately.
  - After release with `req` = 0100 → `grant` = 0100 one edge later.
- Single requester: `req` = 0010, B = 1, others 0.
  - → `grant` = 0010 and `control` = 01 after 1 edge.
  - → `out` = 1 and `out_valid` = 1 after 2 edges.
  - Held indefinitely with no rotation (no other request).
- Round-robin: `req` = 1111, each winner drops its `req` for one cycle after its grant.
  - → grant order A, B, C, D, A, with no idle cycles between grants.
- Hold limit: `MAX_HOLD` = 3, `req` = 0011 held constant.
  - → A granted 3 cycles, then B 3 cycles, then A, and so on.
  - `control` sequence: 00 00 00 01 01 01 00.
- Release to empty: `req` = 1000 granted, then `req` = 0000.
  - → `grant` = 0000 after 1 edge, `out_valid` = 0 one edge later, `control` stays 11.
  - Then `req` = 0001 → A granted (`ptr` = 0 after wrap from D).
- Data path: grant C with `W` = 4, C = 1010 then C = 0101 on consecutive cycles.
  - → `out` = 1010 then 0101, each 1 cycle after being sampled, with `out_valid` = 1 throughout.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin grant with hold limit, driving a registered 4:1 select stage
module mux4_rr_arbiter #(
    parameter int W        = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] C,
    input  logic [W-1:0] D,
    output logic [3:0]   grant,
    output logic [1:0]   control,
    output logic [W-1:0] out,
    output logic         out_valid
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
    state_t       state, state_nx;
    logic [1:0]   ptr, ptr_nx, control_nx, start, pick;
    logic [3:0]   grant_nx, cand;
    logic [7:0]   hold, hold_nx;
    logic         found, keep, others;
    logic [W-1:0] sel_data;

    // first set bit of r walking s, s+1, s+2, s+3 (mod 4); {found, index}
    function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] s);
        logic [1:0] k;
        search = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            k = s + 2'(i);
            if (r[k]) search = {1'b1, k};
        end
    endfunction

    always_comb begin
        cand            = state == BUSY ? req & ~grant : req;
        start           = state == BUSY ? control + 2'd1 : ptr;
        {found, pick}   = search(cand, start);
        others          = |(req & ~grant);
        keep            = state == BUSY && req[control] && (!others || hold < HOLD_LIM);
        state_nx        = state;
        grant_nx        = grant;
        control_nx      = control;
        ptr_nx          = ptr;
        hold_nx         = hold;
        if (state == IDLE) begin
            if (found) begin
                state_nx   = BUSY;
                grant_nx   = 4'b0001 << pick;
                control_nx = pick;
                hold_nx    = 8'd0;
            end
        end else if (keep) begin
            hold_nx = hold == 8'hff ? hold : hold + 8'd1;
        end else begin
            ptr_nx     = control + 2'd1;
            state_nx   = found ? BUSY : IDLE;
            grant_nx   = found ? 4'b0001 << pick : 4'b0000;
            control_nx = found ? pick : control;
            hold_nx    = 8'd0;
        end
    end

    always_comb
        sel_data = control == 2'd0 ? A : control == 2'd1 ? B : control == 2'd2 ? C : D;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            hold      <= 8'd0;
            grant     <= 4'b0000;
            control   <= 2'd0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            hold      <= hold_nx;
            grant     <= grant_nx;
            control   <= control_nx;
            out_valid <= state == BUSY;
            if (state == BUSY) out <= sel_data;
        end
    end
endmodule
